// File: rtl/sbox_builder_if.sv
// Candidate stream and lookup port of the S-box table builder.
// The master side is the upstream/consumer, and the slave side is the builder.
interface sbox_builder_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_dup;
  logic       in_ready;
  logic       lu_en;
  logic       lu_inv;
  logic [7:0] lu_addr;
  logic [7:0] lu_data;
  logic       lu_valid;

  modport master (
    output in_valid, in_data, in_dup, lu_en, lu_inv, lu_addr,
    input  in_ready, lu_data, lu_valid
  );

  modport slave (
    input  in_valid, in_data, in_dup, lu_en, lu_inv, lu_addr,
    output in_ready, lu_data, lu_valid
  );
endinterface

// File: rtl/sbox_builder.sv
// Builds a 256-entry byte permutation (forward + inverse tables) from a stream of candidate bytes.
// If the draw budget runs out, unused values are appended in ascending order.
module sbox_builder #(
  parameter int MAX_DRAW = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  sbox_builder_if.slave bus,
  output logic          busy,
  output logic          done,
  output logic [8:0]    count
);

  typedef enum logic [1:0] {IDLE, COLLECT, FILL, DONE} state_t;

  localparam logic [10:0] DRAW_LAST = 11'(MAX_DRAW - 1);

  state_t       state, state_nxt;
  logic [255:0] used;
  logic [10:0]  draw;
  logic [7:0]   scan;
  logic [7:0]   fwd_mem [256];
  logic [7:0]   inv_mem [256];
  logic         hs, collect_wr, fill_wr, wr_en, last_wr, clear;
  logic [7:0]   wr_val;
  logic [7:0]   lu_data_q;
  logic         lu_valid_q;

  // The local bitmap decides whether a byte is kept, even when upstream says it is unique.
  always_comb begin
    hs         = (state == COLLECT) & bus.in_valid;
    collect_wr = hs & ~bus.in_dup & ~used[bus.in_data];
    fill_wr    = (state == FILL) & ~used[scan];
    wr_en      = collect_wr | fill_wr;
    wr_val     = (state == FILL) ? scan : bus.in_data;
    last_wr    = wr_en & (count == 9'd255);
    clear      = start & ((state == IDLE) | (state == DONE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Completing the table has priority over an exhausted draw budget in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = COLLECT;
      COLLECT: begin
        if (last_wr)                         state_nxt = DONE;
        else if (hs && (draw == DRAW_LAST))  state_nxt = FILL;
      end
      FILL:    if (last_wr) state_nxt = DONE;
      DONE:    if (start) state_nxt = COLLECT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (state == COLLECT);
    busy         = (state == COLLECT) | (state == FILL);
    done         = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      used       <= '0;
      count      <= '0;
      draw       <= '0;
      scan       <= '0;
      lu_valid_q <= 1'b0;
      lu_data_q  <= '0;
    end else begin
      if (clear) begin
        used  <= '0;
        count <= '0;
        draw  <= '0;
        scan  <= '0;
      end else begin
        if (hs) draw <= draw + 11'd1;
        if (wr_en) begin
          used[wr_val] <= 1'b1;
          count        <= count + 9'd1;
        end
        if (state == FILL) scan <= scan + 8'd1;
      end
      // lu_data keeps its last value when no lookup is honoured.
      if ((state == DONE) && bus.lu_en) begin
        lu_valid_q <= 1'b1;
        lu_data_q  <= bus.lu_inv ? inv_mem[bus.lu_addr] : fwd_mem[bus.lu_addr];
      end else begin
        lu_valid_q <= 1'b0;
      end
    end
  end

  // Table RAMs carry no reset; they are only meaningful after a completed build.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fwd_mem[count[7:0]] <= wr_val;
      inv_mem[wr_val]     <= count[7:0];
    end
  end

  assign bus.lu_data  = lu_data_q;
  assign bus.lu_valid = lu_valid_q;

endmodule

// File: tb/tb_sbox_builder.sv
// Scoreboard testbench for sbox_builder: a table model predicts lookups,
// and expected lookup results are queued when requested and popped when lu_valid appears.
module tb_sbox_builder;
  localparam int MAX_DRAW = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done;
  logic [8:0] count;

  sbox_builder_if bus ();

  sbox_builder #(.MAX_DRAW(MAX_DRAW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .count (count)
  );

  always #5 clk = ~clk;

  int         errorCount = 0;
  int         checkCount = 0;
  logic [7:0] luQueue [$];
  logic [7:0] luExpected;
  logic [7:0] mFwd [256];
  logic [7:0] mInv [256];
  logic       mUsed [256];
  int         mCount;
  int         mDraw;
  logic       mCollect;
  logic [7:0] mLastLu;
  int         fillCycles;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic modelClear();
    for (int v = 0; v < 256; v++) mUsed[v] = 1'b0;
    mCount   = 0;
    mDraw    = 0;
    mCollect = 1'b1;
  endtask

  task automatic modelWrite(input logic [7:0] v);
    mFwd[mCount] = v;
    mInv[v]      = 8'(mCount);
    mUsed[v]     = 1'b1;
    mCount++;
  endtask

  task automatic modelHandshake(input logic [7:0] d, input logic dup);
    mDraw++;
    if (!dup && !mUsed[d]) modelWrite(d);
    if (mCount == 256) begin
      mCollect = 1'b0;
    end else if (mDraw == MAX_DRAW) begin
      for (int v = 0; v < 256; v++)
        if (!mUsed[v]) modelWrite(8'(v));
      mCollect = 1'b0;
    end
  endtask

  // One handshake per call; the builder must be ready whenever the model says it is collecting.
  task automatic applyStimulus(input logic [7:0] d, input logic dup);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_dup   = dup;
    checkOutput("in_ready", bus.in_ready, 1);
    @(posedge clk);
    modelHandshake(d, dup);
  endtask

  task automatic endStimulus();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_dup   = 1'b0;
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start        = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    if (!mCollect) modelClear();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int limit, output int cycles);
    cycles = 0;
    while (!done && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("done_reached", done, 1);
  endtask

  task automatic lookup(input logic inv, input logic [7:0] addr, input logic [7:0] expected);
    @(negedge clk);
    bus.lu_en   = 1'b1;
    bus.lu_inv  = inv;
    bus.lu_addr = addr;
    luQueue.push_back(expected);
    mLastLu = expected;
  endtask

  task automatic lookupEnd();
    @(negedge clk);
    bus.lu_en = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("lu_pending", luQueue.size(), 0);
  endtask

  always @(negedge clk) begin
    if (bus.lu_valid === 1'b1) begin
      if (luQueue.size() == 0) begin
        checkOutput("lu_unexpected", 1, 0);
      end else begin
        luExpected = luQueue.pop_front();
        checkOutput("lu_data", bus.lu_data, luExpected);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_dup   = 1'b0;
    bus.lu_en    = 1'b0;
    bus.lu_inv   = 1'b0;
    bus.lu_addr  = '0;
    mCollect     = 1'b0;
    mLastLu      = '0;
    modelClear();
    mCollect     = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_in_ready", bus.in_ready, 0);
    checkOutput("rst_lu_valid", bus.lu_valid, 0);
    checkOutput("rst_lu_data", bus.lu_data, 0);
    checkOutput("rst_count", count, 0);
    rst_n = 1'b1;

    // Repeated byte without upstream dup flag, a flagged unique byte, and start ignored mid-build.
    pulseStart();
    checkOutput("a_busy", busy, 1);
    checkOutput("a_count0", count, 0);
    applyStimulus(8'd5, 1'b0);
    applyStimulus(8'd5, 1'b0);
    applyStimulus(8'd7, 1'b0);
    applyStimulus(8'd9, 1'b1);
    pulseStart();
    checkOutput("a_count_after_start", count, 2);
    checkOutput("a_busy_after_start", busy, 1);
    while (mCollect) applyStimulus(8'($urandom_range(0, 255)), 1'b1);
    endStimulus();
    waitDone(300, fillCycles);
    checkOutput("a_count_full", count, 256);
    lookup(1'b0, 8'd0, 8'd5);
    lookup(1'b0, 8'd1, 8'd7);
    lookup(1'b0, 8'd2, 8'd0);
    lookup(1'b1, 8'd5, 8'd0);
    lookup(1'b1, 8'd7, 8'd1);
    lookup(1'b1, 8'd9, mInv[9]);
    lookupEnd();

    // Descending feed: last write and budget exhaustion coincide, so the build must end in DONE.
    pulseStart();
    checkOutput("b_count0", count, 0);
    for (int i = 255; i >= 0; i--) applyStimulus(8'(i), 1'b0);
    endStimulus();
    checkOutput("b_done", done, 1);
    checkOutput("b_busy", busy, 0);
    checkOutput("b_in_ready", bus.in_ready, 0);
    checkOutput("b_count", count, 256);
    lookup(1'b0, 8'd0, 8'd255);
    lookup(1'b1, 8'd0, 8'd255);
    lookup(1'b0, 8'd255, 8'd0);
    lookup(1'b1, 8'd255, 8'd0);
    lookup(1'b0, 8'd100, 8'd155);
    lookupEnd();

    // Budget exhausted with one byte kept: ascending fill completes the table.
    pulseStart();
    repeat (256) applyStimulus(8'h10, 1'b0);
    endStimulus();
    checkOutput("c_fill_busy", busy, 1);
    checkOutput("c_fill_done", done, 0);
    checkOutput("c_fill_count", count, 1);
    waitDone(300, fillCycles);
    checkOutput("c_fill_cycles_ok", fillCycles <= 256, 1);
    checkOutput("c_count", count, 256);
    lookup(1'b0, 8'd0, 8'h10);
    lookup(1'b0, 8'd1, 8'h00);
    lookup(1'b0, 8'd2, 8'h01);
    lookup(1'b0, 8'd16, 8'h0F);
    lookup(1'b0, 8'd17, 8'h11);
    lookup(1'b1, mFwd[37], 8'd37);
    for (int i = 0; i < 256; i++) lookup(1'b0, 8'(i), mFwd[i]);
    for (int i = 0; i < 256; i++) lookup(1'b1, mFwd[i], 8'(i));
    lookupEnd();

    // Lookup outside DONE, then reset mid-build and confirm used bytes are accepted again.
    pulseStart();
    for (int i = 0; i < 100; i++) applyStimulus(8'(i), 1'b0);
    endStimulus();
    checkOutput("d_count100", count, 100);
    checkOutput("d_busy", busy, 1);
    @(negedge clk);
    bus.lu_en   = 1'b1;
    bus.lu_inv  = 1'b0;
    bus.lu_addr = 8'd3;
    @(negedge clk);
    bus.lu_en = 1'b0;
    checkOutput("d_lu_valid_idle", bus.lu_valid, 0);
    checkOutput("d_lu_data_hold", bus.lu_data, mLastLu);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("d_rst_count", count, 0);
    checkOutput("d_rst_busy", busy, 0);
    checkOutput("d_rst_in_ready", bus.in_ready, 0);
    checkOutput("d_rst_lu_data", bus.lu_data, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    mCollect = 1'b0;
    pulseStart();
    checkOutput("d_count0", count, 0);
    checkOutput("d_busy_again", busy, 1);
    applyStimulus(8'd0, 1'b0);
    applyStimulus(8'd1, 1'b0);
    applyStimulus(8'd2, 1'b0);
    endStimulus();
    checkOutput("d_count3", count, 3);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/sbox_builder.md
SBOX_BUILDER -- requirements
Module: sbox_builder

Interface
REQ-001 Parameter MAX_DRAW, default 1024, is the draw budget (accepted input handshakes) before forced fill; legal range 256..2047.
REQ-002 clk  input  1  single clock; all state on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  one-cycle pulse; begins a new table build.
REQ-005 in_valid  input  1  upstream dedup stage presents a candidate byte.
REQ-006 in_data  input  8  candidate byte from the chaotic sequence.
REQ-007 in_dup  input  1  upstream duplicate flag, aligned with in_data.
REQ-008 in_ready  output  1  block accepts a candidate this cycle.
REQ-009 busy  output  1  build in progress (COLLECT or FILL).
REQ-010 done  output  1  table complete and readable.
REQ-011 count  output  9  entries written so far, 0..256.
REQ-012 lu_en  input  1  lookup request.
REQ-013 lu_inv  input  1  0 = forward table, 1 = inverse table.
REQ-014 lu_addr  input  8  lookup index.
REQ-015 lu_data  output  8  lookup result.
REQ-016 lu_valid  output  1  lu_data valid.

Function
REQ-017 FSM states: IDLE, COLLECT, FILL, DONE.
REQ-018 IDLE -> COLLECT on start; this clears the 256-bit used bitmap, count and the draw counter.
REQ-019 in_ready SHALL be 1 only in COLLECT; a handshake is in_valid & in_ready.
REQ-020 Each handshake increments the 11-bit draw counter, whether or not the byte is kept.
REQ-021 A handshake with in_dup = 0 and used[in_data] = 0 writes fwd[count] = in_data and inv[in_data] = count[7:0], sets used[in_data], and increments count.
REQ-022 A handshake with in_dup = 1 or used[in_data] = 1 is dropped, with no table write.
REQ-023 The local bitmap check is authoritative: an upstream in_dup = 0 on a repeated byte is still dropped.
REQ-024 COLLECT -> DONE when count reaches 256, taking effect the cycle after the 256th write; in_ready deasserts that cycle.
REQ-025 COLLECT -> FILL when the draw counter reaches MAX_DRAW with count < 256.
REQ-026 FILL scans values 0..255 in ascending order, one value per cycle.
REQ-027 For each unused value v, FILL writes fwd[count] = v and inv[v] = count, sets used[v], and increments count.
REQ-028 FILL -> DONE when count = 256; a FILL scan takes at most 256 cycles.
REQ-029 If the 256th write and the MAX_DRAW limit fall in the same cycle, the block SHALL go to DONE, not FILL.
REQ-030 busy = 1 in COLLECT and FILL; done = 1 only in DONE.
REQ-031 Lookups are honoured only in DONE; lu_data is registered one cycle after lu_en, selecting fwd[lu_addr] or inv[lu_addr] per lu_inv.
REQ-032 lu_valid pulses with lu_data; lu_en outside DONE yields lu_valid = 0 and lu_data holds its value.
REQ-033 start in DONE -> COLLECT with a full clear; start in COLLECT or FILL is ignored.
REQ-034 Final fwd SHALL be a permutation of 0..255, and inv[fwd[i]] = i for all i.

Reset
REQ-035 rst_n low, at any time including mid-build, forces IDLE; it clears the used bitmap, count = 0 and the draw counter.
REQ-036 rst_n low also forces in_ready = 0, busy = 0, done = 0, lu_valid = 0 and lu_data = 0.
REQ-037 Table RAM contents are not reset; they are undefined until rebuilt.
REQ-038 Deassertion of rst_n needs no synchronisation beyond the upstream reset synchroniser.

Verification
REQ-039 Feed bytes 255,254,...,0 with in_dup = 0 -> done after 256 handshakes; fwd[0] = 255, inv[0] = 255, count = 256.
REQ-040 Feed 5,5,7 with the second 5 having in_dup = 0 -> second 5 dropped; fwd[0] = 5, fwd[1] = 7, count = 2.
REQ-041 MAX_DRAW = 256, feed 0x10 repeated 256 times -> FILL; fwd[0] = 0x10, fwd[1] = 0x00, fwd[2] = 0x01, fwd[16] = 0x0F, fwd[17] = 0x11; done within 256 further cycles.
REQ-042 Assert rst_n low with count = 100 in COLLECT, then start -> count = 0, busy = 1, and the previously used bytes are accepted again.
REQ-043 In DONE, lu_en = 1, lu_inv = 1, lu_addr = fwd[37] -> next cycle lu_valid = 1, lu_data = 37.
REQ-044 Pulse start mid-COLLECT -> count and the draw counter continue unchanged.
